// File: rtl/sram_pkg.sv
// Shared types for the multi-channel SRAM controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

    typedef enum logic [0:0] {S_INIT, S_RUN} sram_state_t;

    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/sram_arb_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
// Latency: grant is combinational from req, en and rr_ptr.
// Backpressure: non-granted requesters wait; rr_ptr moves past each winner.
module rr_arbiter #(
    parameter int NCH = 2,
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    int               cand;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NCH)
                cand = cand - NCH;
            cand_idx = IDX_W'(cand);
            if (en && !found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (en && |gnt)
            rr_ptr <= (gnt_idx == IDX_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// NCH valid/ready requesters share one single-port SRAM; zero-fill sweep after reset.
// Latency: writes commit on the accept edge; read data one cycle after accept.
// Backpressure: req_ready low during the sweep and for channels not granted this cycle.
module sram_arb_ctrl
    import sram_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 32,
    parameter int NCH        = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            req_valid,
    output logic [NCH-1:0]            req_ready,
    input  logic [NCH-1:0]            req_we,
    input  logic [NCH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NCH*WIDTH-1:0]      req_wdata,
    output logic [NCH-1:0]            rsp_valid,
    output logic [WIDTH-1:0]          rsp_rdata,
    output logic                      init_done
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    sram_state_t           state;
    logic [ADDR_WIDTH-1:0] init_ptr;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic [NCH-1:0]        gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  acc;
    logic                  sel_we;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state == S_RUN),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign acc       = |gnt;
    assign sel_we    = req_we[gnt_idx];
    assign sel_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[gnt_idx*WIDTH +: WIDTH];

    // A full power-of-two array cannot be addressed out of range.
    if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full
        assign in_range = 1'b1;
    end else begin : g_part
        assign in_range = sel_addr < ADDR_WIDTH'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            init_ptr  <= '0;
            init_done <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    rsp_valid <= '0;
                    init_ptr  <= init_ptr + 1'b1;
                    if (init_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    rsp_valid <= (acc && !sel_we) ? gnt : '0;
                    if (acc && !sel_we)
                        rsp_rdata <= in_range ? mem[sel_addr] : '0;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Storage has no reset; the sweep after every reset zero-fills it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT)
                mem[init_ptr] <= '0;
            else if (acc && sel_we && in_range)
                mem[sel_addr] <= sel_wdata;
        end
    end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl: a DEPTH=32 instance and a DEPTH=20 instance.
module tb_sram_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready, req_we, rsp_valid;
    logic [9:0] req_addr;
    logic [7:0] req_wdata;
    logic [3:0] rsp_rdata;
    logic       init_done;

    logic [1:0] req_valid_b, req_ready_b, req_we_b, rsp_valid_b;
    logic [9:0] req_addr_b;
    logic [7:0] req_wdata_b;
    logic [3:0] rsp_rdata_b;
    logic       init_done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arb_ctrl #(.WIDTH(4), .DEPTH(32), .NCH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done)
    );

    sram_arb_ctrl #(.WIDTH(4), .DEPTH(20), .NCH(2)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .init_done(init_done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic we, input logic [4:0] a, input logic [3:0] d);
        req_valid            = '0;
        req_we               = '0;
        req_valid[ch]        = 1'b1;
        req_we[ch]           = we;
        req_addr[ch*5 +: 5]  = a;
        req_wdata[ch*4 +: 4] = d;
    endtask

    task automatic drive_b(input logic we, input logic [4:0] a, input logic [3:0] d);
        req_valid_b       = 2'b01;
        req_we_b          = {1'b0, we};
        req_addr_b[4:0]   = a;
        req_wdata_b[3:0]  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        req_valid_b = 2'b00; req_we_b = 2'b00; req_addr_b = '0; req_wdata_b = '0;
        tick();
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (rsp_rdata !== 4'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b expected 00", req_ready); end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            checks++;
            if (init_done !== (k == 32)) begin
                errors++; $display("FAIL sweep_init_done cycle %0d: got %b expected %b", k, init_done, (k == 32));
            end
            checks++;
            if (req_ready !== ((k == 32) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL sweep_req_ready cycle %0d: got %b expected %b", k, req_ready, ((k == 32) ? 2'b01 : 2'b00));
            end
        end
    endtask

    task automatic test_init_zero();
        for (int a = 0; a < 32; a++) begin
            drive(0, 1'b0, 5'(a), 4'h0);
            tick();
            checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL zero_rsp_valid addr %0d: got %b expected 01", a, rsp_valid); end
            checks++; if (rsp_rdata !== 4'h0) begin errors++; $display("FAIL zero_rdata addr %0d: got %h expected 0", a, rsp_rdata); end
        end
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL zero_rsp_idle: got %b expected 00", rsp_valid); end
    endtask

    task automatic test_write_read();
        for (int a = 0; a < 32; a++) begin
            drive(0, 1'b1, 5'(a), 4'b1010);
            tick();
            checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_no_rsp addr %0d: got %b expected 00", a, rsp_valid); end
        end
        for (int a = 0; a < 32; a++) begin
            drive(0, 1'b0, 5'(a), 4'h0);
            tick();
            checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp_valid addr %0d: got %b expected 01", a, rsp_valid); end
            checks++; if (rsp_rdata !== 4'b1010) begin errors++; $display("FAIL rd_rdata addr %0d: got %b expected 1010", a, rsp_rdata); end
        end
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_pulse_width: got %b expected 00", rsp_valid); end
        checks++; if (rsp_rdata !== 4'b1010) begin errors++; $display("FAIL rd_rdata_hold: got %b expected 1010", rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_v;
        logic [3:0] exp_d;
        drive(0, 1'b1, 5'd3, 4'h3);
        tick();
        drive(1, 1'b1, 5'd5, 4'h5);
        tick();
        req_valid = 2'b11; req_we = 2'b00;
        req_addr[4:0] = 5'd3; req_addr[9:5] = 5'd5;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_first_grant: got %b expected 01", req_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp_d = (i % 2 == 1) ? 4'h5 : 4'h3;
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL b2b_rsp_valid %0d: got %b expected %b", i, rsp_valid, exp_v); end
            checks++; if (rsp_rdata !== exp_d) begin errors++; $display("FAIL b2b_rdata %0d: got %h expected %h", i, rsp_rdata, exp_d); end
            if (i < 3) begin
                checks++; if (req_ready !== ~exp_v) begin errors++; $display("FAIL b2b_grant %0d: got %b expected %b", i + 1, req_ready, ~exp_v); end
            end
        end
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b expected 00", rsp_valid); end
    endtask

    task automatic test_raw();
        drive(0, 1'b1, 5'd7, 4'b0110);
        tick();
        drive(1, 1'b0, 5'd7, 4'h0);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL raw_grant: got %b expected 10", req_ready); end
        tick();
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL raw_rsp_valid: got %b expected 10", rsp_valid); end
        checks++; if (rsp_rdata !== 4'b0110) begin errors++; $display("FAIL raw_rdata: got %b expected 0110", rsp_rdata); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b0, 5'd7, 4'h0);
        tick();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL mid_pre_rsp: got %b expected 01", rsp_valid); end
        checks++; if (rsp_rdata !== 4'b0110) begin errors++; $display("FAIL mid_pre_rdata: got %b expected 0110", rsp_rdata); end
        req_valid = 2'b11; req_we = 2'b00; req_addr[9:5] = 5'd5;
        rst = 1'b1;
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_rsp_dropped: got %b expected 00", rsp_valid); end
        checks++; if (rsp_rdata !== 4'h0) begin errors++; $display("FAIL mid_rdata_reset: got %h expected 0", rsp_rdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_init_done: got %b expected 0", init_done); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_req_ready: got %b expected 00", req_ready); end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k < 32) begin
                checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_sweep_ready cycle %0d: got %b expected 00", k, req_ready); end
            end
        end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL mid_init_done_after: got %b expected 1", init_done); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_rr_ptr_reset: got %b expected 01", req_ready); end
        drive(0, 1'b0, 5'd7, 4'h0);
        tick();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL mid_rd7_valid: got %b expected 01", rsp_valid); end
        checks++; if (rsp_rdata !== 4'h0) begin errors++; $display("FAIL mid_rd7_rdata: got %h expected 0", rsp_rdata); end
        drive(1, 1'b0, 5'd5, 4'h0);
        tick();
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL mid_rd5_valid: got %b expected 10", rsp_valid); end
        checks++; if (rsp_rdata !== 4'h0) begin errors++; $display("FAIL mid_rd5_rdata: got %h expected 0", rsp_rdata); end
        req_valid = '0;
    endtask

    task automatic test_out_of_range();
        checks++; if (init_done_b !== 1'b1) begin errors++; $display("FAIL oob_init_done: got %b expected 1", init_done_b); end
        for (int a = 0; a < 20; a++) begin
            drive_b(1'b1, 5'(a), 4'(a + 1));
            tick();
        end
        drive_b(1'b0, 5'd9, 4'h0);
        tick();
        checks++; if (rsp_rdata_b !== 4'hA) begin errors++; $display("FAIL oob_pre_rdata: got %h expected a", rsp_rdata_b); end
        drive_b(1'b1, 5'd25, 4'b1111);
        tick();
        checks++; if (rsp_valid_b !== 2'b00) begin errors++; $display("FAIL oob_wr_no_rsp: got %b expected 00", rsp_valid_b); end
        drive_b(1'b0, 5'd25, 4'h0);
        tick();
        checks++; if (rsp_valid_b !== 2'b01) begin errors++; $display("FAIL oob_rd_valid: got %b expected 01", rsp_valid_b); end
        checks++; if (rsp_rdata_b !== 4'h0) begin errors++; $display("FAIL oob_rd_rdata: got %h expected 0", rsp_rdata_b); end
        for (int a = 0; a < 20; a++) begin
            drive_b(1'b0, 5'(a), 4'h0);
            tick();
            checks++; if (rsp_rdata_b !== 4'(a + 1)) begin errors++; $display("FAIL oob_unchanged addr %0d: got %h expected %h", a, rsp_rdata_b, 4'(a + 1)); end
        end
        req_valid_b = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_zero();
        test_write_read();
        test_back_to_back();
        test_raw();
        test_reset_mid();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
